// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: datapath width, canonical NOP and the fetch buffer entry.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO with synchronous clear; a pop frees its slot for a push in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  entry_t                  wdata,
  input  logic                    pop,
  input  logic                    clear,
  output entry_t                  head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    cnt_n    = cnt;
    if (clear) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      cnt_n    = '0;
    end else begin
      if (do_pop)  rd_ptr_n = rd_ptr + AW'(1);
      if (do_push) wr_ptr_n = wr_ptr + AW'(1);
      cnt_n = cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      cnt    <= cnt_n;
    end
  end

  // Storage needs no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps at most FIFO_DEPTH fetches in flight or buffered,
// and drops responses belonging to fetches that were in flight when execute redirected.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  input  logic        i_instr_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = CW + 1;

  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] resp_pc, resp_pc_n;
  logic [CW-1:0]   outstanding, outstanding_n;
  logic [CW-1:0]   discard, discard_n;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    fifo_head, push_entry;
  logic [XLEN-1:0] redirect_target;
  logic [BW-1:0]   budget;
  logic            pop, grant, resp, push;

  assign redirect_target = i_redirect_pc & ~32'h3;
  assign pop    = o_instr_valid & i_instr_ready;
  assign budget = {1'b0, outstanding} + {1'b0, fifo_count} - BW'(pop);
  // A slot is reserved for every fetch in flight, so the buffer cannot overflow.
  assign o_imem_req  = i_reset & ~i_redirect & (budget < BW'(FIFO_DEPTH));
  assign o_imem_addr = fetch_pc;
  assign grant = o_imem_req & i_imem_gnt;
  assign resp  = i_imem_rvalid & (outstanding != '0);
  assign push  = resp & ~i_redirect & (discard == '0);
  assign push_entry = '{pc: resp_pc, instr: i_imem_rdata};

  assign o_instr_valid = ~fifo_empty;
  assign o_instruction = o_instr_valid ? fifo_head.instr : NOP_INSTR;
  assign o_pc          = o_instr_valid ? fifo_head.pc    : RESET_PC;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .clear (i_redirect),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Every fetch still in flight at a redirect (minus the one answered now) becomes a discard.
  always_comb begin
    fetch_pc_n    = fetch_pc;
    resp_pc_n     = resp_pc;
    outstanding_n = outstanding;
    discard_n     = discard;
    if (i_redirect) begin
      fetch_pc_n    = redirect_target;
      resp_pc_n     = redirect_target;
      outstanding_n = outstanding - CW'(resp);
      discard_n     = outstanding - CW'(resp);
    end else begin
      if (grant) fetch_pc_n = fetch_pc + 32'd4;
      if (resp) begin
        if (discard != '0) discard_n = discard - CW'(1);
        else               resp_pc_n = resp_pc + 32'd4;
      end
      outstanding_n = outstanding + CW'(grant) - CW'(resp);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      resp_pc     <= resp_pc_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(i_imem_rvalid && outstanding == '0));
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory with programmable latency plus a stream model of expected PCs.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, req, gnt, rvalid, redirect, valid, ready;
  logic [31:0] addr, rdata, redirect_pc, instr, pc;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_valid (valid),
    .o_instruction (instr),
    .o_pc          (pc),
    .i_instr_ready (ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    mem_lat = 1;
  int    grant_cnt = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Memory: answers granted requests in order, mem_lat cycles after the grant.
  initial begin
    rvalid = 1'b0;
    rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        rvalid = 1'b1;
        rdata  = memfn(mq[0].a);
        void'(mq.pop_front());
      end else begin
        rvalid = 1'b0;
        rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Stream model: after reset/redirect, requests and delivered PCs each walk target, +4, +8, ...
  initial begin
    logic [31:0] exp_pc, exp_req;
    int live;
    bit prev_stall;
    exp_pc = RESET_PC; exp_req = RESET_PC; live = 0; prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        mq.delete();
        exp_pc = RESET_PC; exp_req = RESET_PC; live = 0; prev_stall = 0;
      end else if (redirect) begin
        chk("redir_req", 32'(req), 32'd0);
        exp_pc = {redirect_pc[31:2], 2'b00};
        exp_req = exp_pc; live = 0; prev_stall = 0;
      end else begin
        if (prev_stall) chk("hold_valid", 32'(valid), 32'd1);
        if (req) begin
          chk("req_addr", addr, exp_req);
          if (gnt) begin
            mq.push_back('{a: addr, due: cyc + mem_lat});
            exp_req += 32'd4; live++; grant_cnt++;
          end
        end
        if (valid) begin
          chk("head_pc", pc, exp_pc);
          chk("head_instr", instr, memfn(exp_pc));
          if (ready) begin exp_pc += 32'd4; live--; end
        end
        chk("live_cap", 32'(live <= int'(DEPTH)), 32'd1);
        prev_stall = valid && !ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] epc);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (valid) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_pc"}, pc, epc);
      chk({nm, "_instr"}, instr, memfn(epc));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1; gnt = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_addr", addr, RESET_PC);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, RESET_PC);

    // Streaming from reset with 1-cycle memory
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_req", 32'(req), 32'd1);
    chk("t1_first_addr", addr, 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_pc0", pc, 32'h0);
    chk("t1_instr0", instr, 32'hC0DE_0000);
    tick(); @(negedge clk); chk("t1_pc1", pc, 32'h4);
    tick(); @(negedge clk); chk("t1_pc2", pc, 32'h8);
    repeat (6) tick();

    // Decode stalled for 10 cycles from reset
    rst_n = 1'b0; tick();
    rst_n = 1'b1; ready = 1'b0; g0 = grant_cnt;
    repeat (10) tick();
    chk("t2_grants", 32'(grant_cnt - g0), 32'd4);
    chk("t2_req_blocked", 32'(req), 32'd0);
    chk("t2_head_pc", pc, 32'h0);
    chk("t2_head_instr", instr, 32'hC0DE_0000);
    ready = 1'b1;
    repeat (8) tick();

    // Redirect with 3-cycle memory and fetches in flight
    mem_lat = 3;
    repeat (10) tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick(); redirect = 1'b0;
    wait_valid("t3", 32'h100);
    chk("t3_instr_lit", instr, 32'hF7A7_B100);
    repeat (4) tick();

    // Back-to-back redirects, then one separated by a single fetch
    redirect = 1'b1; redirect_pc = 32'h300;
    tick(); redirect_pc = 32'h400;
    tick(); redirect = 1'b0;
    wait_valid("t3b", 32'h400);
    tick(); redirect = 1'b1; redirect_pc = 32'h500;
    tick(); redirect = 1'b0;
    tick(); redirect = 1'b1; redirect_pc = 32'h600;
    tick(); redirect = 1'b0;
    wait_valid("t3c", 32'h600);
    repeat (4) tick();

    // Redirect coinciding with a response and an accepted handshake
    mem_lat = 1;
    repeat (8) tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    chk("t4_rvalid", 32'(rvalid), 32'd1);
    chk("t4_handshake", 32'(valid & ready), 32'd1);
    tick(); redirect = 1'b0;
    wait_valid("t4", 32'h40);
    repeat (3) tick();

    // Misaligned target and address wrap
    redirect = 1'b1; redirect_pc = 32'h203;
    tick(); redirect = 1'b0;
    @(negedge clk);
    chk("t5_req", 32'(req), 32'd1);
    chk("t5_addr", addr, 32'h200);
    wait_valid("t5", 32'h200);
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect = 1'b0;
    wait_valid("t5w", 32'hFFFF_FFF8);
    tick(); @(negedge clk); chk("t5_pc_fffc", pc, 32'hFFFF_FFFC);
    tick(); @(negedge clk); chk("t5_pc_wrap", pc, 32'h0);
    repeat (4) tick();

    // One-cycle reset pulse mid-stream
    rst_n = 1'b0; #1;
    chk("t6_valid_async", 32'(valid), 32'd0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("t6_req", 32'(req), 32'd1);
    chk("t6_addr", addr, RESET_PC);
    wait_valid("t6", RESET_PC);
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. It owns the program counter, issues word requests to instruction memory over a request/grant interface, and buffers returned instructions with their PC. It presents them over a valid/ready handshake to the decode stage, which feeds the immediate generator and the control decoder. It also accepts redirects (branch/jump/trap targets) from execute and discards any fetches that are in flight at that point.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2; also the cap on outstanding plus buffered fetches
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0
- i_imem_gnt  in  1  memory accepts the request this cycle; meaningful only while o_imem_req=1
- i_imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant
- i_imem_rdata  in  32  instruction word
- i_redirect  in  1  flush and restart fetch
- i_redirect_pc  in  32  restart address; bits [1:0] are ignored and treated as 0
- o_instr_valid  out  1  buffer head valid
- o_instruction  out  32  buffer head instruction
- o_pc  out  32  PC of o_instruction
- i_instr_ready  in  1  decode accepts the head

## Operation
- Registers:
  - fetch_pc: next address to request.
  - resp_pc: PC of the oldest non-discarded outstanding fetch.
  - outstanding: count, 0..FIFO_DEPTH.
  - discard: count of responses to drop.
  - FIFO of {pc, instruction}.
- Request rule:
  - o_imem_req = ~i_redirect && (outstanding + fifo_count − pop < FIFO_DEPTH).
  - pop = o_instr_valid && i_instr_ready.
  - o_imem_addr = fetch_pc.
- Grant: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
- Response with discard = 0: push {resp_pc, i_imem_rdata}, resp_pc += 4, outstanding −= 1.
- Response with discard > 0: word is dropped, discard −= 1, outstanding −= 1.
- Redirect cycle:
  - FIFO cleared; a handshake in this cycle does not count.
  - discard ← outstanding − (i_imem_rvalid ? 1 : 0); the response in this cycle is dropped.
  - fetch_pc and resp_pc ← {i_redirect_pc[31:2], 2'b00}.
  - No request is issued.
- Back-to-back redirects: the later one wins, and discard accumulates correctly.
- The buffer never overflows, because the request rule reserves a slot per outstanding fetch.
- An rvalid while outstanding = 0 is a protocol error: ignored, and asserted in simulation.

## Timing
- Reset values:
  - o_imem_req = 0 during reset; 1 from the first cycle after reset deasserts.
  - o_imem_addr = RESET_PC.
  - o_instr_valid = 0.
  - o_instruction = 32'h0000_0013 (NOP).
  - o_pc = RESET_PC.
  - All counters 0.
- Latency: grant at T, rvalid at T+1, o_instr_valid at T+2. Outputs come from FIFO registers; there is no combinational rdata→o_instruction path.
- Throughput: 1 instruction/cycle with 1-cycle memory latency and ready held high.
- First request after a redirect at T: cycle T+1, address = redirect target.
- o_instruction and o_pc hold stable while o_instr_valid=1 and i_instr_ready=0.
- Reset mid-operation: all state clears asynchronously. Responses arriving after reset for pre-reset requests are not tracked; memory is reset from the same i_reset.

## Structure
- Shared package rv_pkg holds:
  - XLEN = 32.
  - NOP_INSTR = 32'h0000_0013.
  - the typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo:
  - parameterised on depth and entry type.
  - push/pop/clear, count, full, empty.
  - simultaneous push and pop when full is legal, given pop is evaluated first.

## Test plan
- Reset release, memory always grants with 1-cycle rvalid, ready=1 → addresses 0,4,8,…; o_pc 0,4,8 on consecutive cycles from cycle 3.
- i_instr_ready=0 for 10 cycles while streaming → requests stop at outstanding + count = 4. Head holds PC 0x0 and its word; then the stream resumes with no gap or duplicate.
- Memory latency 3 cycles, redirect to 0x100 with 3 fetches outstanding → the 3 stale words are dropped; next o_pc = 0x100 with mem[0x100].
- Redirect asserted in the same cycle as rvalid and an accepted handshake → no stale instruction appears; discard = outstanding − 1; the first valid output is the target.
- Redirect to 0x203 → first request address 0x200, o_pc 0x200; fetch_pc at 0xFFFF_FFFC wraps to 0x0.
- Reset asserted mid-stream for 1 cycle → o_instr_valid=0 immediately; the first request after release is to RESET_PC.
